// File: rtl/uart_pkg.sv
// Shared constants, FSM state encoding and baud increment helper for the UART receiver.
package uart_pkg;

  localparam int unsigned PARITY_NONE = 0;
  localparam int unsigned PARITY_ODD  = 1;
  localparam int unsigned PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_e;

  // round(baud * ovs * 2^acc_w / clk_freq) in 64-bit integer arithmetic
  function automatic longint unsigned baud_inc(input longint unsigned clk_freq,
                                               input longint unsigned baud,
                                               input longint unsigned ovs,
                                               input longint unsigned acc_w);
    longint unsigned num;
    num = baud * ovs * (64'd1 << acc_w);
    return (num + clk_freq / 2) / clk_freq;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with registered head, valid, level and full/empty flags.
module sync_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             valid_o,
  output logic [LVL_W-1:0] level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic             valid_q, full_q, empty_q;
  logic             pop_ok, wr_ok;

  assign pop_ok = pop_i && !empty_q;
  assign wr_ok  = push_i && (!full_q || pop_ok);

  // Next head is looked up ahead so the head register holds the word at the new read pointer.
  always_comb begin
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(wr_ok);
    level_d  = level_q + LVL_W'(wr_ok) - LVL_W'(pop_ok);
    head_d   = '0;
    if (level_d != '0) begin
      if (wr_ok && (wr_ptr_q == rd_ptr_d)) begin
        head_d = wdata_i;
      end else begin
        head_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= (level_d != '0);
      full_q   <= (level_d == LVL_W'(DEPTH));
      empty_q  <= (level_d == '0);
    end
  end

  assign rdata_o = head_q;
  assign valid_o = valid_q;
  assign level_o = level_q;
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling async-serial receiver with majority voting, error flags and an output FIFO.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 19_200,
  parameter int unsigned OVS       = 16,
  parameter int unsigned ACC_W     = 16,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned IDLE_BITS = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rxd,
  output logic [DATA_BITS-1:0]         rx_data,
  output logic                         rx_perr,
  output logic                         rx_ferr,
  output logic                         rx_break,
  output logic                         rx_valid,
  input  logic                         rx_ready,
  output logic                         rx_overrun,
  output logic                         rx_idle,
  output logic [$clog2(DEPTH + 1)-1:0] fifo_level
);

  localparam int unsigned S_W      = $clog2(OVS);
  localparam int unsigned BIT_W    = $clog2(DATA_BITS);
  localparam int unsigned FW       = DATA_BITS + 3;
  localparam int unsigned IDLE_LIM = IDLE_BITS * OVS;
  localparam int unsigned IC_W     = $clog2(IDLE_LIM + 1);

  localparam logic [ACC_W:0] INC =
    (ACC_W + 1)'(baud_inc(64'(CLK_FREQ), 64'(BAUD), 64'(OVS), 64'(ACC_W)));
  localparam logic [S_W-1:0]  S_LO    = S_W'(OVS / 2 - 1);
  localparam logic [S_W-1:0]  S_MID   = S_W'(OVS / 2);
  localparam logic [S_W-1:0]  S_DEC   = S_W'(OVS / 2 + 1);
  localparam logic [S_W-1:0]  S_MAX   = S_W'(OVS - 1);
  localparam logic [BIT_W-1:0] B_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [IC_W-1:0] IC_LIM  = IC_W'(IDLE_LIM);
  localparam logic            HAS_PAR = (PARITY != PARITY_NONE);
  localparam logic            IS_ODD  = (PARITY == PARITY_ODD);

  if (OVS < 8 || OVS > 16 || (OVS % 2) != 0) begin : g_bad_ovs
    $error("uart_rx_fifo: OVS must be even and within 8..16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_fifo: DATA_BITS must be within 5..9");
  end
  if (PARITY > PARITY_EVEN) begin : g_bad_parity
    $error("uart_rx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_rx_fifo: STOP_BITS must be 1 or 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end

  logic [1:0]           sync_q;
  logic                 rxd_s;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [ACC_W:0]       sum_c;
  logic                 tick_c;
  rx_state_e            state_q;
  logic [S_W-1:0]       s_q;
  logic [BIT_W-1:0]     bit_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 perr_q, par_bit_q;
  logic [1:0]           samp_q;
  logic                 vote_c, decide_c, exp_par_c;
  logic                 ferr_c, brk_c, push_c;
  logic [FW-1:0]        wdata_c, head_w;
  logic                 fifo_full, fifo_empty, pop_ok_c;
  logic                 overrun_q;
  logic                 leave_c;
  logic [IC_W-1:0]      icnt_q, icnt_d;
  logic                 idle_q;

  // Two-flop synchronizer, preset high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rxd};
    end
  end
  assign rxd_s = sync_q[1];

  // Free-running fractional baud accumulator; its carry is the oversampling tick.
  assign sum_c  = {1'b0, acc_q} + INC;
  assign tick_c = sum_c[ACC_W];
  assign acc_d  = sum_c[ACC_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign vote_c    = (samp_q[1] & samp_q[0]) | (samp_q[1] & rxd_s) | (samp_q[0] & rxd_s);
  assign decide_c  = tick_c && (s_q == S_DEC) && (state_q != ST_IDLE);
  assign exp_par_c = IS_ODD ? ~(^data_q) : (^data_q);

  assign ferr_c  = ~vote_c;
  assign brk_c   = ferr_c && (data_q == '0) && (!HAS_PAR || !par_bit_q);
  assign push_c  = decide_c && (state_q == ST_STOP);
  assign wdata_c = {brk_c, ferr_c, perr_q, data_q};

  // Frame FSM; the stop decision returns to idle mid-bit so the next start edge is caught.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      bit_q     <= '0;
      data_q    <= '0;
      perr_q    <= 1'b0;
      par_bit_q <= 1'b0;
      samp_q    <= '0;
    end else begin
      if (state_q != ST_IDLE && tick_c) begin
        s_q <= (s_q == S_MAX) ? '0 : s_q + S_W'(1);
        if (s_q == S_LO || s_q == S_MID) begin
          samp_q <= {samp_q[0], rxd_s};
        end
      end
      unique case (state_q)
        ST_IDLE: begin
          s_q <= '0;
          if (!rxd_s) begin
            state_q   <= ST_START;
            bit_q     <= '0;
            perr_q    <= 1'b0;
            par_bit_q <= 1'b0;
          end
        end
        ST_START: begin
          if (decide_c) begin
            state_q <= vote_c ? ST_IDLE : ST_DATA;
          end
        end
        ST_DATA: begin
          if (decide_c) begin
            data_q <= {vote_c, data_q[DATA_BITS-1:1]};
            bit_q  <= bit_q + BIT_W'(1);
            if (bit_q == B_LAST) begin
              state_q <= HAS_PAR ? ST_PARITY : ST_STOP;
            end
          end
        end
        ST_PARITY: begin
          if (decide_c) begin
            perr_q    <= vote_c ^ exp_par_c;
            par_bit_q <= vote_c;
            state_q   <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (decide_c) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_c),
    .wdata_i (wdata_c),
    .pop_i   (rx_ready),
    .rdata_o (head_w),
    .valid_o (rx_valid),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign pop_ok_c = rx_ready && !fifo_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= push_c && fifo_full && !pop_ok_c;
    end
  end

  // Idle counter: runs only while idle with the line high, saturates at the threshold.
  assign leave_c = (state_q == ST_IDLE) && !rxd_s;

  always_comb begin
    icnt_d = icnt_q;
    if (state_q != ST_IDLE || leave_c) begin
      icnt_d = '0;
    end else if (tick_c && icnt_q != IC_LIM) begin
      icnt_d = icnt_q + IC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      icnt_q <= '0;
      idle_q <= 1'b0;
    end else begin
      icnt_q <= icnt_d;
      idle_q <= (icnt_d == IC_LIM);
    end
  end

  assign rx_data    = head_w[DATA_BITS-1:0];
  assign rx_perr    = head_w[DATA_BITS];
  assign rx_ferr    = head_w[DATA_BITS+1];
  assign rx_break   = head_w[DATA_BITS+2];
  assign rx_overrun = overrun_q;
  assign rx_idle    = idle_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: 8N1/DEPTH=4 instance (a) and even-parity instance (b), scoreboarded.
module tb_uart_rx_fifo;

  localparam int unsigned DA = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rxd_a, rxd_b, rdy_a, rdy_b;
  logic [7:0] data_a, data_b;
  logic       perr_a, ferr_a, brk_a, valid_a, ovr_a, idle_a;
  logic       perr_b, ferr_b, brk_b, valid_b, ovr_b, idle_b;
  logic [2:0] lvl_a;
  logic [3:0] lvl_b;

  uart_rx_fifo #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .OVS(16), .ACC_W(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .DEPTH(DA), .IDLE_BITS(16)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_a), .rx_data(data_a), .rx_perr(perr_a),
    .rx_ferr(ferr_a), .rx_break(brk_a), .rx_valid(valid_a), .rx_ready(rdy_a),
    .rx_overrun(ovr_a), .rx_idle(idle_a), .fifo_level(lvl_a)
  );

  uart_rx_fifo #(
    .CLK_FREQ(1_600_000), .BAUD(100_000), .OVS(16), .ACC_W(16), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .DEPTH(8), .IDLE_BITS(16)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .rxd(rxd_b), .rx_data(data_b), .rx_perr(perr_b),
    .rx_ferr(ferr_b), .rx_break(brk_b), .rx_valid(valid_b), .rx_ready(rdy_b),
    .rx_overrun(ovr_b), .rx_idle(idle_b), .fifo_level(lvl_b)
  );

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       f;
    logic       b;
  } exp_t;

  typedef struct {
    bit         sel;
    logic [7:0] d;
    logic       pb;
    logic       stop;
    logic [7:0] ed;
    logic       ep;
    logic       ef;
    logic       eb;
  } vec_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rise_a = 0;
  int   ovr_cnt_a = 0;
  int   ovr_cnt_b = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Consumer monitors: compare every popped word against the scoreboard head.
  initial begin : mon_a
    exp_t e;
    logic pv;
    pv = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid_a && rdy_a) begin
          if (q_a.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_word: got 0x%0h, expected no word", data_a);
          end else begin
            e = q_a.pop_front();
            chk("a_data", 32'(data_a), 32'(e.d));
            chk("a_perr", 32'(perr_a), 32'(e.p));
            chk("a_ferr", 32'(ferr_a), 32'(e.f));
            chk("a_break", 32'(brk_a), 32'(e.b));
          end
        end
        if (ovr_a) ovr_cnt_a++;
        if (valid_a && !pv) rise_a = cyc;
      end
      pv = valid_a;
    end
  end

  initial begin : mon_b
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (valid_b && rdy_b) begin
          if (q_b.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_word: got 0x%0h, expected no word", data_b);
          end else begin
            e = q_b.pop_front();
            chk("b_data", 32'(data_b), 32'(e.d));
            chk("b_perr", 32'(perr_b), 32'(e.p));
            chk("b_ferr", 32'(ferr_b), 32'(e.f));
            chk("b_break", 32'(brk_b), 32'(e.b));
          end
        end
        if (ovr_b) ovr_cnt_b++;
      end
    end
  end

  task automatic drive_bit(input bit sel, input logic v);
    @(posedge clk);
    #1;
    if (sel) rxd_b = v;
    else rxd_a = v;
    repeat (15) @(posedge clk);
  endtask

  task automatic send(input bit sel, input logic [7:0] d, input logic par_en,
                      input logic par_bit, input logic stop, output int t0);
    @(posedge clk);
    #1;
    t0 = cyc;
    if (sel) rxd_b = 1'b0;
    else rxd_a = 1'b0;
    repeat (15) @(posedge clk);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (par_en) drive_bit(sel, par_bit);
    drive_bit(sel, stop);
    drive_bit(sel, 1'b1);
    drive_bit(sel, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0) && n < 400) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    chk(name, 32'(q_a.size() + q_b.size()), 32'd0);
  endtask

  initial begin : watchdog
    #600_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

  initial begin : main
    vec_t tv[10];
    int   t0;
    int   exp_ovr;

    tv[0] = '{0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
    tv[1] = '{0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
    tv[2] = '{0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    tv[3] = '{0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 1'b0};
    tv[4] = '{0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tv[5] = '{1, 8'h03, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
    tv[6] = '{1, 8'h03, 1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
    tv[7] = '{1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 1'b0};
    tv[8] = '{1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
    tv[9] = '{1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};

    rst_n = 1'b0;
    rxd_a = 1'b1;
    rxd_b = 1'b1;
    rdy_a = 1'b1;
    rdy_b = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(valid_a), 32'd0);
    chk("rst_data", 32'(data_a), 32'd0);
    chk("rst_flags", 32'({perr_a, ferr_a, brk_a}), 32'd0);
    chk("rst_overrun", 32'(ovr_a), 32'd0);
    chk("rst_idle", 32'(idle_a), 32'd0);
    chk("rst_level", 32'(lvl_a), 32'd0);
    chk("rst_b_valid", 32'(valid_b), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);

    for (int i = 0; i < 10; i++) begin
      if (tv[i].sel) q_b.push_back('{tv[i].ed, tv[i].ep, tv[i].ef, tv[i].eb});
      else q_a.push_back('{tv[i].ed, tv[i].ep, tv[i].ef, tv[i].eb});
      send(tv[i].sel, tv[i].d, tv[i].sel, tv[i].pb, tv[i].stop, t0);
      if (i == 0) chk("latency_start_to_valid", 32'(rise_a - t0), 32'd157);
      drain("vec_drain");
    end

    // Line held low for ten bit times: one break word, trailing low rejected as a glitch.
    q_a.push_back('{8'h00, 1'b0, 1'b1, 1'b1});
    @(posedge clk);
    #1 rxd_a = 1'b0;
    repeat (160) @(posedge clk);
    #1 rxd_a = 1'b1;
    repeat (64) @(posedge clk);
    drain("break_drain");
    chk("break_level", 32'(lvl_a), 32'd0);

    // Three-clock glitch: nothing written, and a following frame still decodes.
    @(posedge clk);
    #1 rxd_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rxd_a = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("glitch_level", 32'(lvl_a), 32'd0);
    chk("glitch_valid", 32'(valid_a), 32'd0);
    q_a.push_back('{8'h81, 1'b0, 1'b0, 1'b0});
    send(0, 8'h81, 1'b0, 1'b0, 1'b1, t0);
    drain("glitch_next_drain");

    // Overrun: fill a DEPTH=4 FIFO with no consumer, the fifth word is dropped.
    rdy_a = 1'b0;
    exp_ovr = 0;
    for (int w = 0; w < 5; w++) begin
      if (q_a.size() < DA) q_a.push_back('{8'(w), 1'b0, 1'b0, 1'b0});
      else exp_ovr++;
      send(0, 8'(w), 1'b0, 1'b0, 1'b1, t0);
    end
    @(negedge clk);
    chk("ovr_level", 32'(lvl_a), 32'd4);
    chk("ovr_pulses", 32'(ovr_cnt_a), 32'(exp_ovr));
    chk("ovr_head_stable", 32'(data_a), 32'h00);
    @(posedge clk);
    #1 rdy_a = 1'b1;
    drain("ovr_drain");
    chk("ovr_pulses_after_pop", 32'(ovr_cnt_a), 32'(exp_ovr));

    // Reset mid-frame with a word queued: FIFO flushed, partial frame lost.
    rdy_a = 1'b0;
    send(0, 8'h33, 1'b0, 1'b0, 1'b1, t0);
    @(negedge clk);
    chk("pre_reset_level", 32'(lvl_a), 32'd1);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b0);
    drive_bit(0, 1'b1);
    drive_bit(0, 1'b0);
    @(posedge clk);
    #1 rxd_a = 1'b1;
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    rdy_a = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(valid_a), 32'd0);
    chk("mid_rst_level", 32'(lvl_a), 32'd0);
    chk("mid_rst_data", 32'(data_a), 32'd0);
    chk("mid_rst_overrun", 32'(ovr_a), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    q_a.push_back('{8'h5A, 1'b0, 1'b0, 1'b0});
    send(0, 8'h5A, 1'b0, 1'b0, 1'b1, t0);
    drain("post_reset_drain");
    @(negedge clk);
    chk("idle_early", 32'(idle_a), 32'd0);
    repeat (260) @(posedge clk);
    @(negedge clk);
    chk("idle_after_256", 32'(idle_a), 32'd1);

    // Idle drops as soon as a start edge leaves IDLE.
    @(posedge clk);
    #1 rxd_a = 1'b0;
    repeat (6) @(negedge clk);
    chk("idle_drop", 32'(idle_a), 32'd0);
    @(posedge clk);
    #1 rxd_a = 1'b1;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("idle_glitch_level", 32'(lvl_a), 32'd0);

    chk("b_level_end", 32'(lvl_b), 32'd0);
    chk("b_overrun_end", 32'(ovr_cnt_b), 32'd0);
    chk("b_idle_end", 32'(idle_b), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
